// File: rtl/crc16_frame_rx.sv
// Serial receiver for 40-bit frames: 24-bit payload then CRC-16-CCITT (poly 0x1021, init 0),
// MSB-first. Recomputes the CRC bit-serially and reports payload plus pass/fail.
module crc16_frame_rx #(
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   input  logic                 bit_valid,
   input  logic                 bit_in,
   output logic [23:0]          payload_out,
   output logic                 out_valid,
   output logic                 crc_ok,
   output logic                 crc_err,
   output logic                 busy,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PAYLOAD = 2'd1;
   localparam logic [1:0] CRC     = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [15:0] POLY = 16'h1021;

   logic [1:0]           state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [23:0]          pay_q, pay_d;
   logic [15:0]          rx_crc_q, rx_crc_d;
   logic [23:0]          payload_q, payload_d;
   logic                 ok_q, ok_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic                 fb;
   logic [15:0]          lfsr_step;
   logic [15:0]          rx_crc_step;
   logic                 crc_match;

   always_comb begin
      fb          = bit_in ^ lfsr_q[15];
      lfsr_step   = {lfsr_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      rx_crc_step = {rx_crc_q[14:0], bit_in};
      // The last CRC bit is still on bit_in when DONE is entered, so compare the shifted value.
      crc_match   = (rx_crc_step == lfsr_q);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lfsr_d    = lfsr_q;
      pay_d     = pay_q;
      rx_crc_d  = rx_crc_q;
      payload_d = payload_q;
      ok_d      = ok_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;

      if (frame_start) begin
         // Restart from any state; a bit presented alongside frame_start is dropped.
         state_d = PAYLOAD;
         cnt_d   = 5'd0;
         lfsr_d  = 16'h0000;
      end else begin
         unique case (state_q)
            IDLE: begin
            end
            PAYLOAD: begin
               if (bit_valid) begin
                  lfsr_d = lfsr_step;
                  pay_d  = {pay_q[22:0], bit_in};
                  if (cnt_q == 5'd23) begin
                     cnt_d   = 5'd0;
                     state_d = CRC;
                  end else begin
                     cnt_d = cnt_q + 5'd1;
                  end
               end
            end
            CRC: begin
               if (bit_valid) begin
                  rx_crc_d = rx_crc_step;
                  if (cnt_q == 5'd15) begin
                     cnt_d     = 5'd0;
                     state_d   = DONE;
                     payload_d = pay_q;
                     ok_d      = crc_match;
                     err_d     = !crc_match;
                     if (!crc_match && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 5'd1;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         lfsr_q    <= 16'h0000;
         pay_q     <= 24'h000000;
         rx_crc_q  <= 16'h0000;
         payload_q <= 24'h000000;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         pay_q     <= pay_d;
         rx_crc_q  <= rx_crc_d;
         payload_q <= payload_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      payload_out = payload_q;
      out_valid   = (state_q == DONE);
      crc_ok      = ok_q;
      crc_err     = err_q;
      busy        = (state_q == PAYLOAD) || (state_q == CRC);
      err_count   = err_cnt_q;
   end

endmodule

// File: doc/crc16_frame_rx.md
Name: crc16_frame_rx

Overview:
Serial receiver/checker for the 40-bit CRC-protected frame: 24-bit payload followed by a 16-bit CRC-16-CCITT, MSB-first.
- CRC parameters: init 0x0000, poly 0x1021, no reflection, xorout 0x0000.
- Deserialises the payload and recomputes the CRC bit-serially with an LFSR as bits arrive.
- Compares against the received CRC field and reports payload plus pass/fail.
- Sits at the receive end of the link, opposite the CRC generator on the transmit side.

Parameters:
ERR_CNT_W, 8, width of the saturating CRC-error counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
frame_start  in  1  sync pulse; marks the cycle before the first frame bit; aborts any frame in progress
bit_valid  in  1  bit_in is valid this cycle (gaps allowed)
bit_in  in  1  serial frame bit, MSB-first
payload_out  out  24  received payload, held until next out_valid
out_valid  out  1  single-cycle pulse: frame complete, payload_out/crc_ok/crc_err valid
crc_ok  out  1  received CRC equals computed CRC (qualified by out_valid, held)
crc_err  out  1  received CRC differs from computed CRC (qualified by out_valid, held)
busy  out  1  frame reception in progress (state PAYLOAD or CRC)
err_count  out  ERR_CNT_W  saturating count of frames with crc_err since reset

Behaviour:
- Reset (async, active-high):
  - State = IDLE; bit counter = 0; LFSR = 0x0000; shift registers = 0.
  - All outputs = 0, including payload_out and err_count.
- States: IDLE, PAYLOAD, CRC, DONE.
- IDLE:
  - bit_valid is ignored.
  - frame_start=1 → PAYLOAD next cycle; LFSR cleared to 0x0000; bit counter cleared.
- PAYLOAD: per cycle with bit_valid=1:
  - fb = bit_in ^ lfsr[15]; lfsr = {lfsr[14:0],0} ^ (fb ? 0x1021 : 0).
  - Payload shift register shifts left, bit_in enters at the LSB.
  - Counter increments.
  - After the 24th accepted bit → CRC.
- CRC: per bit_valid:
  - LFSR frozen.
  - Received-CRC register shifts left with bit_in.
  - After the 16th accepted bit → DONE.
- DONE (exactly one cycle):
  - out_valid=1.
  - payload_out updated.
  - crc_ok = (rx_crc == lfsr); crc_err = !crc_ok.
  - err_count += crc_err, saturating at all-ones.
  - → IDLE.
- Latency: out_valid asserts on the cycle immediately after the clock edge that accepts the 40th bit. Cycles with bit_valid=0 stall without effect.
- out_valid is a pulse. payload_out, crc_ok and crc_err hold their values until the next DONE. They are not cleared by frame_start or abort.
- busy=1 in PAYLOAD and CRC only.
- frame_start while busy:
  - Current frame is discarded; no out_valid; err_count unchanged.
  - Restarts at PAYLOAD with LFSR and counter cleared.
  - A bit_valid in the same cycle as frame_start is ignored.
- frame_start during DONE: DONE completes normally (out_valid still pulses), then → PAYLOAD instead of IDLE.
- bit_valid during DONE is ignored; the transmitter guarantees at least one idle cycle between frames.
- Reset mid-frame: immediate return to reset state; no out_valid.
- The bit counter counts 0..23 and then 0..15; it never wraps within a state.

Test Plan:
- Reset, frame_start, then bits of payload 0x000001 + CRC 0x1021 with continuous bit_valid → out_valid exactly 41 cycles after frame_start; payload_out=0x000001, crc_ok=1, crc_err=0, err_count=0.
- Payload 0x000002 + CRC 0x2042, with bit_valid low on every third cycle → same result (crc_ok=1, payload_out=0x000002); latency extended by the gap cycles only.
- Payload 0x000001 + corrupted CRC 0x1020 → crc_ok=0, crc_err=1, err_count=1. A following frame 0x000000/0x0000 → crc_ok=1, err_count stays 1.
- frame_start after 10 bits of a frame, then a full valid 0x000002/0x2042 frame → only one out_valid pulse, with payload_out=0x000002 and crc_ok=1.
- Assert rst after 30 bits → all outputs 0 immediately. Then a new full frame decodes correctly.
- 256 consecutive bad-CRC frames with ERR_CNT_W=8 → err_count saturates at 255 and does not wrap.
